// File: rtl/interval_sequencer_pkg.sv
// Shared phase encodings for the interval sequencer and display drivers.
// Phase codes double as the value driven on the phase output.
package interval_sequencer_pkg;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_WORK = 2'd1;
  localparam logic [1:0] PH_REST = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  function automatic logic is_running(input logic [1:0] ph);
    return (ph == PH_WORK) || (ph == PH_REST);
  endfunction

endpackage

// File: rtl/interval_sequencer_prescaler.sv
// One-second tick generator for the interval sequencer.
// Counts 0..TICK_DIV-1 while enabled; tick is the wrap cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 40_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/interval_sequencer.sv
// Work/rest interval engine: round sequencing, countdown, pause,
// skip, soft clear and buzzer timing.
module interval_sequencer
  import interval_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 40_000_000,
  parameter int TIME_W   = 9,
  parameter int ROUND_W  = 4,
  parameter int BUZZ_CYC = 4_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TIME_W-1:0]  cfg_work,
  input  logic [TIME_W-1:0]  cfg_rest,
  input  logic [ROUND_W-1:0] cfg_rounds,
  input  logic               start,
  input  logic               skip,
  input  logic               clr,
  output logic [1:0]         phase,
  output logic [TIME_W-1:0]  remaining,
  output logic [ROUND_W-1:0] round_idx,
  output logic               paused,
  output logic               sec_tick,
  output logic               buzzer
);

  localparam int BUZZ_W = $clog2(3 * BUZZ_CYC + 1);
  localparam logic [BUZZ_W-1:0] BUZZ_SHORT = BUZZ_W'(BUZZ_CYC);
  localparam logic [BUZZ_W-1:0] BUZZ_LONG  = BUZZ_W'(3 * BUZZ_CYC);

  logic [TIME_W-1:0]  work_q;
  logic [TIME_W-1:0]  rest_q;
  logic [ROUND_W-1:0] rounds_q;
  logic [BUZZ_W-1:0]  buzz_cnt;

  logic running;
  logic tick;
  logic start_ok;
  logic phase_end;
  logic last_round;
  logic to_rest;
  logic ps_clear;

  assign running    = is_running(phase);
  assign start_ok   = start && !running &&
                      (cfg_work != '0) && (cfg_rounds != '0);
  assign phase_end  = running &&
                      (skip || (tick && remaining == TIME_W'(1)));
  assign last_round = (phase == PH_WORK) && (round_idx == rounds_q);
  assign to_rest    = (phase == PH_WORK) && !last_round &&
                      (rest_q != '0);
  assign ps_clear   = clr || phase_end || start_ok;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(ps_clear),
    .en   (running && !paused),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase     <= PH_IDLE;
      remaining <= '0;
      round_idx <= '0;
      paused    <= 1'b0;
      sec_tick  <= 1'b0;
      buzzer    <= 1'b0;
      buzz_cnt  <= '0;
      work_q    <= '0;
      rest_q    <= '0;
      rounds_q  <= '0;
    end else begin
      sec_tick <= tick;
      if (buzz_cnt != '0) begin
        buzz_cnt <= buzz_cnt - BUZZ_W'(1);
        buzzer   <= (buzz_cnt != BUZZ_W'(1));
      end
      if (!running) begin
        if (phase == PH_IDLE) remaining <= cfg_work;
        if (start_ok) begin
          work_q    <= cfg_work;
          rest_q    <= cfg_rest;
          rounds_q  <= cfg_rounds;
          phase     <= PH_WORK;
          remaining <= cfg_work;
          round_idx <= ROUND_W'(1);
          paused    <= 1'b0;
        end
      end else if (phase_end) begin
        buzzer <= 1'b1;
        // Skip keeps the pause state; only completion drops it.
        unique case (1'b1)
          last_round: begin
            phase     <= PH_DONE;
            remaining <= '0;
            paused    <= 1'b0;
            buzz_cnt  <= BUZZ_LONG;
          end
          to_rest: begin
            phase     <= PH_REST;
            remaining <= rest_q;
            buzz_cnt  <= BUZZ_SHORT;
          end
          default: begin
            phase     <= PH_WORK;
            remaining <= work_q;
            round_idx <= round_idx + ROUND_W'(1);
            buzz_cnt  <= BUZZ_SHORT;
          end
        endcase
      end else if (tick) begin
        remaining <= remaining - TIME_W'(1);
      end else if (start) begin
        paused <= !paused;
      end
    end
  end

endmodule

// File: tb/tb_interval_sequencer.sv
// Directed bench for interval_sequencer, TICK_DIV=4 and BUZZ_CYC=3.
module tb_interval_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] cfg_work;
  logic [8:0] cfg_rest;
  logic [3:0] cfg_rounds;
  logic       start;
  logic       skip;
  logic       clr;
  logic [1:0] phase;
  logic [8:0] remaining;
  logic [3:0] round_idx;
  logic       paused;
  logic       sec_tick;
  logic       buzzer;

  int checks   = 0;
  int failures = 0;

  interval_sequencer #(
    .TICK_DIV(4),
    .TIME_W  (9),
    .ROUND_W (4),
    .BUZZ_CYC(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_work  (cfg_work),
    .cfg_rest  (cfg_rest),
    .cfg_rounds(cfg_rounds),
    .start     (start),
    .skip      (skip),
    .clr       (clr),
    .phase     (phase),
    .remaining (remaining),
    .round_idx (round_idx),
    .paused    (paused),
    .sec_tick  (sec_tick),
    .buzzer    (buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_skip();
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ph"}, phase, 0);
    chk({tag, "_rm"}, remaining, 0);
    chk({tag, "_rd"}, round_idx, 0);
    chk({tag, "_bz"}, buzzer, 0);
    chk({tag, "_ps"}, paused, 0);
    chk({tag, "_st"}, sec_tick, 0);
  endtask

  int t1_k [14] = '{0, 3, 4, 8, 12, 14, 15, 16, 20, 24, 28, 32, 40, 41};
  int t1_ph[14] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 3, 3, 3};
  int t1_rm[14] = '{3, 3, 2, 1, 2, 2, 2, 1, 3, 2, 1, 0, 0, 0};
  int t1_rd[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2};
  int t1_bz[14] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0};

  int t2_k [5] = '{0, 4, 8, 16, 24};
  int t2_ph[5] = '{1, 1, 1, 1, 3};
  int t2_rm[5] = '{2, 1, 2, 2, 0};
  int t2_rd[5] = '{1, 1, 2, 3, 3};
  int t2_bz[5] = '{0, 0, 1, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int nt;
    int nb;
    int nr;
    int np;
    int n;
    rst = 1'b1;
    start = 1'b0;
    skip = 1'b0;
    clr = 1'b0;
    cfg_work = 9'd3;
    cfg_rest = 9'd2;
    cfg_rounds = 4'd2;
    cyc(2);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mirror", remaining, 3);
    chk("idle_ph", phase, 0);

    // work=3 rest=2 rounds=2
    pulse_start();
    p = 0; nt = 0; nb = 0;
    for (int k = 0; k <= 42; k++) begin
      if (p < 14 && k == t1_k[p]) begin
        chk($sformatf("t1_ph_k%0d", k), phase, t1_ph[p]);
        chk($sformatf("t1_rm_k%0d", k), remaining, t1_rm[p]);
        chk($sformatf("t1_rd_k%0d", k), round_idx, t1_rd[p]);
        chk($sformatf("t1_bz_k%0d", k), buzzer, t1_bz[p]);
        p++;
      end
      nt += int'(sec_tick);
      nb += int'(buzzer);
      @(negedge clk);
    end
    chk("t1_ticks", nt, 8);
    chk("t1_buzz_cyc", nb, 15);

    // rest=0: back-to-back work phases, restarted from DONE
    cfg_work = 9'd2;
    cfg_rest = 9'd0;
    cfg_rounds = 4'd3;
    pulse_start();
    p = 0; nr = 0;
    for (int k = 0; k <= 30; k++) begin
      if (p < 5 && k == t2_k[p]) begin
        chk($sformatf("t2_ph_k%0d", k), phase, t2_ph[p]);
        chk($sformatf("t2_rm_k%0d", k), remaining, t2_rm[p]);
        chk($sformatf("t2_rd_k%0d", k), round_idx, t2_rd[p]);
        chk($sformatf("t2_bz_k%0d", k), buzzer, t2_bz[p]);
        p++;
      end
      if (phase == 2'd2) nr++;
      @(negedge clk);
    end
    chk("t2_no_rest", nr, 0);

    // pause/resume, then skip and mid-run switch changes
    cfg_work = 9'd3;
    cfg_rest = 9'd2;
    cfg_rounds = 4'd2;
    pulse_start();
    cyc(4);
    chk("t3_rm_k4", remaining, 2);
    chk("t3_tick_k4", sec_tick, 1);
    start = 1'b1;
    nt = 0; np = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_work = 9'd7;
      cfg_rest = 9'd5;
      cfg_rounds = 4'd1;
      nt += int'(sec_tick);
      if (paused && remaining == 9'd2) np++;
    end
    chk("t3_pause_ticks", nt, 0);
    chk("t3_pause_hold", np, 20);
    pulse_start();
    n = 0;
    while (!sec_tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t3_resume_lat", n, 3);
    chk("t3_resume_rm", remaining, 1);
    chk("t3_resume_ps", paused, 0);
    pulse_skip();
    chk("t4_skip_ph", phase, 2);
    chk("t4_skip_rm", remaining, 2);
    chk("t4_skip_rd", round_idx, 1);
    chk("t4_skip_bz", buzzer, 1);
    cyc(3);
    chk("t4_presc_rm", remaining, 2);
    chk("t4_presc_st", sec_tick, 0);
    @(negedge clk);
    chk("t4_tick_rm", remaining, 1);
    chk("t4_tick_st", sec_tick, 1);
    cyc(3);
    pulse_skip();
    chk("t4_st_ph", phase, 1);
    chk("t4_st_rd", round_idx, 2);
    chk("t4_st_rm", remaining, 3);
    cyc(3);
    pulse_skip();
    chk("t4_done_ph", phase, 3);
    chk("t4_done_rm", remaining, 0);
    chk("t4_done_bz", buzzer, 1);

    // soft clear, then rejected starts
    pulse_clr();
    chk_reset("t5_clr");
    @(negedge clk);
    chk("t5_mirror", remaining, 7);
    cfg_rounds = 4'd0;
    pulse_start();
    chk("t5_r0_ph", phase, 0);
    chk("t5_r0_rm", remaining, 7);
    cfg_work = 9'd0;
    cfg_rounds = 4'd2;
    pulse_start();
    chk("t5_w0_ph", phase, 0);
    chk("t5_w0_rm", remaining, 0);
    chk("t5_w0_rd", round_idx, 0);

    // clr mid-REST, rst mid-buzz
    cfg_work = 9'd1;
    cfg_rest = 9'd3;
    cfg_rounds = 4'd2;
    pulse_start();
    chk("t6_ph", phase, 1);
    chk("t6_rm", remaining, 1);
    cyc(4);
    chk("t6_rest_ph", phase, 2);
    chk("t6_rest_rm", remaining, 3);
    pulse_clr();
    chk_reset("t6_clr");
    pulse_start();
    cyc(4);
    chk("t6_buzz", buzzer, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t6_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_rm", remaining, 1);
    chk("t6_post_bz", buzzer, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
